// File: rtl/ans_pkg.sv
// rtl/ans_pkg.sv - shared ANS op encodings, controller states and width defaults
package ans_pkg;

  localparam int SYM_WIDTH_DEF = 4;
  localparam int LEN_WIDTH_DEF = 8;

  // Op codes 01/10/11 double as the datapath mode select.
  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_ENC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ENC,
    ST_DEC,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/ans_xfer_counter.sv
// rtl/ans_xfer_counter.sv - loadable transfer down-counter with last (==1) flag
module ans_xfer_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Clear beats load beats decrement; never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/ans_ctrl.sv
// rtl/ans_ctrl.sv - ANS command sequencer: mode select, symbol gating, drain and table tracking
module ans_ctrl
  import ans_pkg::*;
#(
  parameter int SYM_WIDTH = SYM_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [1:0]           cmd_op,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 abort,
  input  logic                 sym_vld,
  output logic                 sym_rdy,
  output logic [1:0]           dp_cmd,
  output logic                 dp_in_vld,
  input  logic                 dp_in_rdy,
  input  logic                 dp_idle,
  output logic                 busy,
  output logic                 table_ok,
  output logic                 err
);

  localparam int CW = LEN_WIDTH + 1;
  localparam logic [CW-1:0] TBL_LEN = CW'(1) << SYM_WIDTH;

  state_e        state;
  logic          active;
  logic          accept;
  logic          xfer;
  logic          last;
  logic          cnt_load;
  logic          cnt_clr;
  logic          cnt_dec;
  logic [CW-1:0] cnt_val;

  assign active    = (state == ST_LOAD) || (state == ST_ENC) || (state == ST_DEC);
  assign busy      = (state != ST_IDLE);
  assign cmd_rdy   = (state == ST_IDLE) && !abort;
  assign accept    = cmd_vld && cmd_rdy;
  assign sym_rdy   = active && dp_in_rdy;
  assign dp_in_vld = active && sym_vld;
  assign xfer      = active && sym_vld && dp_in_rdy;

  assign cnt_clr  = abort && busy;
  assign cnt_dec  = xfer && !abort;
  assign cnt_load = accept && ((cmd_op == OP_LOAD) ||
                    (table_ok && ((cmd_op == OP_ENC) || (cmd_op == OP_DEC))));
  assign cnt_val  = (cmd_op == OP_LOAD) ? TBL_LEN : (CW'(cmd_len) + CW'(1));

  ans_xfer_counter #(.WIDTH(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dp_cmd   <= OP_CLR;
      table_ok <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_op == OP_CLR) begin
              table_ok <= 1'b0;
            end else if (cmd_op == OP_LOAD) begin
              table_ok <= 1'b0;
              dp_cmd   <= OP_LOAD;
              state    <= ST_LOAD;
            end else if (table_ok) begin
              dp_cmd <= cmd_op;
              state  <= (cmd_op == OP_ENC) ? ST_ENC : ST_DEC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD, ST_ENC, ST_DEC: begin
          // Abort wins over a same-cycle final transfer, so a cut-short load never sets table_ok.
          if (abort) begin
            state  <= ST_IDLE;
            dp_cmd <= OP_CLR;
          end else if (xfer && last) begin
            state <= ST_DRAIN;
            if (state == ST_LOAD) table_ok <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (abort || dp_idle) begin
            state  <= ST_IDLE;
            dp_cmd <= OP_CLR;
          end
        end
        default: begin
          state  <= ST_IDLE;
          dp_cmd <= OP_CLR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ans_ctrl.sv
// tb/tb_ans_ctrl.sv - randomized self-checking bench for ans_ctrl against a transfer-count model
module tb_ans_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  logic       abort;
  logic       sym_vld;
  logic       sym_rdy;
  logic [1:0] dp_cmd;
  logic       dp_in_vld;
  logic       dp_in_rdy;
  logic       dp_idle;
  logic       busy;
  logic       table_ok;
  logic       err;

  int checks = 0;
  int fails  = 0;
  logic exp_tok = 1'b0;

  ans_ctrl dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .abort(abort), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .dp_cmd(dp_cmd), .dp_in_vld(dp_in_vld), .dp_in_rdy(dp_in_rdy), .dp_idle(dp_idle),
    .busy(busy), .table_ok(table_ok), .err(err)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] op, input logic [7:0] len);
    @(negedge clk);
    cmd_vld = 1'b1; cmd_op = op; cmd_len = len;
    sym_vld = 1'b1; dp_in_rdy = 1'b1; dp_idle = 1'b0; abort = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL issue_cmd_rdy got %b exp 1", cmd_rdy); end
    checks++; if (sym_rdy !== 1'b0) begin fails++; $display("FAIL accept_sym_rdy got %b exp 0", sym_rdy); end
    if (op == 2'b00 || op == 2'b11) exp_tok = 1'b0;
  endtask

  task automatic do_xfers(input int n, input logic [1:0] exp_cmd, input bit toggle);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < n * 8 + 64) begin
      @(negedge clk);
      cmd_vld = 1'b0; dp_idle = 1'b0;
      sym_vld   = ($urandom_range(0, 3) != 0);
      dp_in_rdy = toggle ? cyc[0] : ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (dp_cmd !== exp_cmd) begin fails++; $display("FAIL xfer_dp_cmd got %b exp %b", dp_cmd, exp_cmd); end
      checks++; if (dp_in_vld !== sym_vld || sym_rdy !== dp_in_rdy) begin
        fails++; $display("FAIL xfer_gate got vld %b rdy %b exp %b %b", dp_in_vld, sym_rdy, sym_vld, dp_in_rdy);
      end
      if (sym_vld && sym_rdy) cnt++;
      cyc++;
    end
    checks++; if (cnt != n) begin fails++; $display("FAIL xfer_count got %0d exp %0d (timeout)", cnt, n); end
  endtask

  task automatic drain(input logic [1:0] exp_cmd);
    int hold = $urandom_range(0, 3);
    @(negedge clk);
    sym_vld = 1'b1; dp_in_rdy = 1'b1; dp_idle = 1'b0;
    #1;
    checks++; if (sym_rdy !== 1'b0 || dp_in_vld !== 1'b0) begin
      fails++; $display("FAIL drain_no_xfer got rdy %b vld %b exp 0 0", sym_rdy, dp_in_vld);
    end
    checks++; if (busy !== 1'b1 || dp_cmd !== exp_cmd) begin
      fails++; $display("FAIL drain_hold got busy %b cmd %b exp 1 %b", busy, dp_cmd, exp_cmd);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      checks++; if (busy !== 1'b1 || dp_cmd !== exp_cmd) begin
        fails++; $display("FAIL drain_wait got busy %b cmd %b exp 1 %b", busy, dp_cmd, exp_cmd);
      end
    end
    @(negedge clk); dp_idle = 1'b1;
    @(negedge clk); dp_idle = 1'b0; sym_vld = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || dp_cmd !== 2'b00 || cmd_rdy !== 1'b1) begin
      fails++; $display("FAIL drain_exit got busy %b cmd %b rdy %b exp 0 00 1", busy, dp_cmd, cmd_rdy);
    end
    checks++; if (table_ok !== exp_tok) begin fails++; $display("FAIL drain_table_ok got %b exp %b", table_ok, exp_tok); end
  endtask

  task automatic expect_reject();
    @(negedge clk); cmd_vld = 1'b0; #1;
    checks++; if (err !== 1'b1 || busy !== 1'b0 || dp_cmd !== 2'b00) begin
      fails++; $display("FAIL reject got err %b busy %b cmd %b exp 1 0 00", err, busy, dp_cmd);
    end
    @(negedge clk); #1;
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_pulse_width got %b exp 0", err); end
  endtask

  task automatic load_table();
    issue(2'b11, 8'd0);
    do_xfers(16, 2'b11, 1'b1);
    exp_tok = 1'b1;
    drain(2'b11);
  endtask

  task automatic test_reset();
    sym_vld = 1'b1; dp_in_rdy = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || cmd_rdy !== 1'b1 || sym_rdy !== 1'b0 || dp_in_vld !== 1'b0) begin
      fails++; $display("FAIL reset_hs got busy %b rdy %b srdy %b vld %b exp 0 1 0 0", busy, cmd_rdy, sym_rdy, dp_in_vld);
    end
    checks++; if (dp_cmd !== 2'b00 || table_ok !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL reset_regs got cmd %b tok %b err %b exp 00 0 0", dp_cmd, table_ok, err);
    end
  endtask

  task automatic test_reject();
    issue(2'b01, 8'd3);
    expect_reject();
    issue(2'b10, 8'($urandom_range(0, 255)));
    expect_reject();
  endtask

  task automatic test_load();
    load_table();
  endtask

  task automatic test_enc_dec();
    issue(2'b01, 8'd0);
    do_xfers(1, 2'b01, 1'b0);
    drain(2'b01);
    issue(2'b10, 8'd255);
    do_xfers(256, 2'b10, 1'b0);
    drain(2'b10);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] op;
      int len;
      op  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      len = $urandom_range(0, 40);
      issue(op, 8'(len));
      do_xfers(len + 1, op, 1'b0);
      drain(op);
    end
  endtask

  task automatic test_abort_load();
    issue(2'b11, 8'd0);
    do_xfers(7, 2'b11, 1'b0);
    @(negedge clk); abort = 1'b1; sym_vld = 1'b0; #1;
    checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL abort_cmd_rdy got %b exp 0", cmd_rdy); end
    @(negedge clk); abort = 1'b0; #1;
    checks++; if (busy !== 1'b0 || dp_cmd !== 2'b00 || table_ok !== exp_tok) begin
      fails++; $display("FAIL abort_load got busy %b cmd %b tok %b exp 0 00 %b", busy, dp_cmd, table_ok, exp_tok);
    end
    issue(2'b01, 8'd5);
    expect_reject();
  endtask

  task automatic test_abort_final();
    int len = $urandom_range(1, 12);
    load_table();
    issue(2'b01, 8'(len));
    do_xfers(len, 2'b01, 1'b0);
    @(negedge clk); abort = 1'b1; sym_vld = 1'b1; dp_in_rdy = 1'b1;
    @(negedge clk); abort = 1'b0; sym_vld = 1'b0; #1;
    checks++; if (busy !== 1'b0 || dp_cmd !== 2'b00 || table_ok !== exp_tok) begin
      fails++; $display("FAIL abort_final got busy %b cmd %b tok %b exp 0 00 %b", busy, dp_cmd, table_ok, exp_tok);
    end
    issue(2'b00, 8'd0);
    @(negedge clk); cmd_vld = 1'b0; #1;
    checks++; if (table_ok !== exp_tok || busy !== 1'b0) begin
      fails++; $display("FAIL clear_table got tok %b busy %b exp %b 0", table_ok, busy, exp_tok);
    end
  endtask

  task automatic test_async_reset();
    load_table();
    issue(2'b01, 8'd20);
    do_xfers(5, 2'b01, 1'b0);
    @(negedge clk); sym_vld = 1'b1; dp_in_rdy = 1'b1; #1;
    checks++; if (dp_in_vld !== 1'b1) begin fails++; $display("FAIL pre_rst_vld got %b exp 1", dp_in_vld); end
    #1 rst = 1'b1;
    exp_tok = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cmd_rdy !== 1'b1 || sym_rdy !== 1'b0 || dp_in_vld !== 1'b0) begin
      fails++; $display("FAIL async_rst_hs got busy %b rdy %b srdy %b vld %b exp 0 1 0 0", busy, cmd_rdy, sym_rdy, dp_in_vld);
    end
    checks++; if (dp_cmd !== 2'b00 || table_ok !== exp_tok || err !== 1'b0) begin
      fails++; $display("FAIL async_rst_regs got cmd %b tok %b err %b exp 00 0 0", dp_cmd, table_ok, err);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || sym_rdy !== 1'b0) begin
      fails++; $display("FAIL post_rst_idle got busy %b srdy %b exp 0 0", busy, sym_rdy);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_op = 2'b00; cmd_len = 8'd0; abort = 1'b0;
    sym_vld = 1'b0; dp_in_rdy = 1'b0; dp_idle = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_reject();
    test_load();
    test_enc_dec();
    test_abort_load();
    test_abort_final();
    test_async_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
